seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter NDIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 100000, clock cycles per digit slot; SHALL be >= GUARD+2.
REQ-003 Parameter GUARD, default 2, cycles at the start of each slot with all anodes off (anti-ghosting).
REQ-004 Parameter LZB, default 0, leading-zero blanking enable (1 = on).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 load  input  1  single-cycle strobe; captures digits, dp_in and blank_in.
REQ-008 digits  input  4*NDIGITS  digit codes; bits [4i+3:4i] belong to digit i; digit 0 is rightmost.
REQ-009 dp_in  input  NDIGITS  decimal point request per digit, 1 = lit.
REQ-010 blank_in  input  NDIGITS  per-digit forced blank, 1 = dark.
REQ-011 seg  output  7  segments {a,b,c,d,e,f,g}, MSB = a, active-low (0 = lit).
REQ-012 dp_out  output  1  decimal point of the current digit, active-low.
REQ-013 an  output  NDIGITS  digit enables, active-low; at most one bit low at any time.
REQ-014 frame_done  output  1  one-cycle pulse at the end of each full scan frame.

Function
REQ-015 Slot counter cnt SHALL count 0..SCAN_DIV-1 and wrap; digit index idx SHALL advance by 1 modulo NDIGITS on each cnt wrap.
REQ-016 Double buffering: load SHALL write a shadow register; the active (displayed) register SHALL copy the shadow only at frame boundary, i.e. the edge where cnt==SCAN_DIV-1 and idx==NDIGITS-1.
REQ-017 When load coincides with a frame boundary, the active register SHALL take the load inputs directly, not the old shadow; the shadow also takes them.
REQ-018 seg, dp_out, an and frame_done SHALL be registered, with one-cycle latency: the outputs in cycle t+1 are a function of cnt, idx and active in cycle t.
REQ-019 an[idx] SHALL be low only when cnt >= GUARD and digit idx is not blanked; all other an bits SHALL be high.
REQ-020 A digit SHALL be blanked if its blank_in bit is 1, or if LZB=1, idx != 0, and that digit and every more-significant digit hold code 0.
REQ-021 While blanked or in guard, seg SHALL be 7'b1111111 and dp_out SHALL be 1.
REQ-022 Otherwise, seg SHALL be decoded from the digit code (abcdefg, 0 = lit) as follows: 0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111 8:0000000 9:0000100 A('-'):1111110 B('n'):1101010 C('C'):0110001 D('d'):1000010 E('E'):0110000 F('U'):1000001.
REQ-023 In the same case, dp_out SHALL be the inverse of the active dp bit of the digit.
REQ-024 frame_done SHALL be 1 for exactly one cycle, in the cycle after the frame-boundary edge; its period SHALL be NDIGITS*SCAN_DIV cycles.
REQ-025 With NDIGITS=1, idx SHALL stay 0, and frame_done SHALL pulse on every cnt wrap.

Reset
REQ-026 While rst=1, independent of clk: cnt=0, idx=0, shadow and active digits=0, dp bits=0, blank bits all 1, an all 1, seg=7'b1111111, dp_out=1, frame_done=0.
REQ-027 After rst deasserts, scanning SHALL start at idx 0, cnt 0; the display SHALL stay dark until a load has been transferred at a frame boundary.
REQ-028 Reset asserted mid-slot or mid-load SHALL discard the pending load; no partial update SHALL be visible.

Verification (NDIGITS=4, SCAN_DIV=8, GUARD=2 unless stated)
REQ-029 rst pulse mid-slot while an=4'b1110 -> an=4'b1111, seg=7'b1111111, dp_out=1 in the same cycle, before any clock edge.
REQ-030 load digits=16'h1234, dp_in=4'b0100, blank_in=0 -> from the next frame: slot 0 an=1110, seg=1001100; slot 2 an=1011, seg=0010010, dp_out=0; an high during cnt 0..1 of each slot.
REQ-031 load 16'h5678 mid-frame while 16'h1234 is displayed -> the remaining slots of that frame still show 1234; 5678 appears only after frame_done.
REQ-032 load asserted in the frame-boundary cycle -> the new value is displayed in the immediately following frame; frame_done period measures 32 cycles.
REQ-033 LZB=1, digits=16'h0070 -> an[3] and an[2] never low; digit 1 seg=0001111; digit 0 seg=0000001.
REQ-034 NDIGITS=1, sweep codes 0..F -> seg matches every table entry in REQ-022; frame_done pulses every 8 cycles.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment driver: double-buffered digit/dp/blank registers,
// per-slot guard band, optional leading-zero blanking and registered outputs.
module seven_seg_scanner #(
   parameter int NDIGITS  = 4,
   parameter int SCAN_DIV = 100000,
   parameter int GUARD    = 2,
   parameter int LZB      = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [4*NDIGITS-1:0]   digits,
   input  logic [NDIGITS-1:0]     dp_in,
   input  logic [NDIGITS-1:0]     blank_in,
   output logic [6:0]             seg,
   output logic                   dp_out,
   output logic [NDIGITS-1:0]     an,
   output logic                   frame_done
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int NSLOT = 1 << IDX_W;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIGITS - 1);

   logic [CNT_W-1:0]     cnt_reg;
   logic [IDX_W-1:0]     idx_reg;
   logic [4*NDIGITS-1:0] shadow_digits_reg;
   logic [NDIGITS-1:0]   shadow_dp_reg;
   logic [NDIGITS-1:0]   shadow_blank_reg;
   logic [4*NDIGITS-1:0] active_digits_reg;
   logic [NDIGITS-1:0]   active_dp_reg;
   logic [NDIGITS-1:0]   active_blank_reg;
   logic [6:0]           seg_reg;
   logic                 dp_out_reg;
   logic [NDIGITS-1:0]   an_reg;
   logic                 frame_done_reg;

   logic [CNT_W-1:0]     cnt_next;
   logic [IDX_W-1:0]     idx_next;
   logic [6:0]           seg_next;
   logic                 dp_out_next;
   logic [NDIGITS-1:0]   an_next;
   logic                 slot_end;
   logic                 frame_end;

   logic [3:0]           slot_code [NSLOT];
   logic [NSLOT-1:0]     slot_dp;
   logic [NSLOT-1:0]     slot_forced;
   logic [NSLOT-1:0]     slot_blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] s;
      unique case (code)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b1111110;
         4'hB: s = 7'b1101010;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b1000001;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   assign slot_end  = (cnt_reg == CNT_LAST);
   assign frame_end = slot_end && (idx_reg == IDX_LAST);

   always_comb begin
      cnt_next = slot_end ? '0 : cnt_reg + 1'b1;
      idx_next = idx_reg;
      if (slot_end) begin
         idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
         idx_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
         idx_reg <= idx_next;
      end
   end

   // A load landing on the frame boundary goes straight to the active copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_digits_reg <= '0;
         shadow_dp_reg     <= '0;
         shadow_blank_reg  <= '1;
         active_digits_reg <= '0;
         active_dp_reg     <= '0;
         active_blank_reg  <= '1;
      end else begin
         if (load) begin
            shadow_digits_reg <= digits;
            shadow_dp_reg     <= dp_in;
            shadow_blank_reg  <= blank_in;
         end
         if (frame_end) begin
            active_digits_reg <= load ? digits   : shadow_digits_reg;
            active_dp_reg     <= load ? dp_in    : shadow_dp_reg;
            active_blank_reg  <= load ? blank_in : shadow_blank_reg;
         end
      end
   end

   // Pad to a power-of-two slot table so idx never indexes past the array.
   genvar gi;
   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_slot
         if (gi < NDIGITS) begin : g_used
            assign slot_code[gi]   = active_digits_reg[4*gi +: 4];
            assign slot_dp[gi]     = active_dp_reg[gi];
            assign slot_forced[gi] = active_blank_reg[gi];
         end else begin : g_pad
            assign slot_code[gi]   = 4'h0;
            assign slot_dp[gi]     = 1'b0;
            assign slot_forced[gi] = 1'b1;
         end
      end
   endgenerate

   always_comb begin
      logic lz;
      lz         = 1'b1;
      slot_blank = '1;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         lz = lz & (slot_code[i] == 4'h0);
         slot_blank[i] = slot_forced[i] | ((LZB != 0) && (i != 0) && lz);
      end
   end

   always_comb begin
      logic [NSLOT-1:0] an_wide;
      an_wide     = '1;
      seg_next    = 7'b1111111;
      dp_out_next = 1'b1;
      if ((cnt_reg >= CNT_GUARD) && !slot_blank[idx_reg]) begin
         an_wide[idx_reg] = 1'b0;
         seg_next         = seg_decode(slot_code[idx_reg]);
         dp_out_next      = ~slot_dp[idx_reg];
      end
      an_next = an_wide[NDIGITS-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_reg        <= 7'b1111111;
         dp_out_reg     <= 1'b1;
         an_reg         <= '1;
         frame_done_reg <= 1'b0;
      end else begin
         seg_reg        <= seg_next;
         dp_out_reg     <= dp_out_next;
         an_reg         <= an_next;
         frame_done_reg <= frame_end;
      end
   end

   assign seg        = seg_reg;
   assign dp_out     = dp_out_reg;
   assign an         = an_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: three instances (4-digit, 4-digit
// with leading-zero blanking, 1-digit), expected frames queued and popped per cycle.
module tb_seven_seg_scanner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [31:0] sb_q [$];

   // Instance A: NDIGITS=4, LZB=0
   logic        rst_a, load_a, dpo_a, fd_a;
   logic [15:0] digits_a;
   logic [3:0]  dp_a, blank_a, an_a;
   logic [6:0]  seg_a;
   // Instance B: NDIGITS=4, LZB=1
   logic        rst_b, load_b, dpo_b, fd_b;
   logic [15:0] digits_b;
   logic [3:0]  dp_b, blank_b, an_b;
   logic [6:0]  seg_b;
   // Instance C: NDIGITS=1
   logic        rst_c, load_c, dpo_c, fd_c;
   logic [3:0]  digits_c;
   logic [0:0]  dp_c, blank_c, an_c;
   logic [6:0]  seg_c;

   seven_seg_scanner #(.NDIGITS(4), .SCAN_DIV(8), .GUARD(2), .LZB(0)) dut_a (
      .clk(clk), .rst(rst_a), .load(load_a), .digits(digits_a), .dp_in(dp_a),
      .blank_in(blank_a), .seg(seg_a), .dp_out(dpo_a), .an(an_a), .frame_done(fd_a));
   seven_seg_scanner #(.NDIGITS(4), .SCAN_DIV(8), .GUARD(2), .LZB(1)) dut_b (
      .clk(clk), .rst(rst_b), .load(load_b), .digits(digits_b), .dp_in(dp_b),
      .blank_in(blank_b), .seg(seg_b), .dp_out(dpo_b), .an(an_b), .frame_done(fd_b));
   seven_seg_scanner #(.NDIGITS(1), .SCAN_DIV(8), .GUARD(2), .LZB(0)) dut_c (
      .clk(clk), .rst(rst_c), .load(load_c), .digits(digits_c), .dp_in(dp_c),
      .blank_in(blank_c), .seg(seg_c), .dp_out(dpo_c), .an(an_c), .frame_done(fd_c));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // Packed view: [16]=frame_done [15]=dp_out [14:8]=seg [7:0]=an
   function automatic logic [31:0] obs(input int sel);
      logic [31:0] o;
      case (sel)
         0:       o = {15'b0, fd_a, dpo_a, seg_a, 4'b0, an_a};
         1:       o = {15'b0, fd_b, dpo_b, seg_b, 4'b0, an_b};
         default: o = {15'b0, fd_c, dpo_c, seg_c, 7'b0, an_c};
      endcase
      return o;
   endfunction

   function automatic logic [6:0] ref_seg(input logic [3:0] c);
      logic [6:0] s;
      case (c)
         4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
         4'hA: s = 7'b1111110;  4'hB: s = 7'b1101010;
         4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;  default: s = 7'b1000001;
      endcase
      return s;
   endfunction

   // Expected output in the j-th cycle (1-based) after a frame_done pulse.
   function automatic logic [31:0] exp_entry(input int nd, input int lzb, input logic [31:0] dg,
                                             input logic [7:0] dpv, input logic [7:0] bl, input int j);
      int s, c;
      logic allz, blanked, dp;
      logic [7:0] an;
      logic [6:0] sg;
      s = (j - 1) / 8;
      c = (j - 1) % 8;
      allz = 1'b1;
      for (int k = s; k < nd; k++) if (dg[4*k +: 4] != 4'h0) allz = 1'b0;
      blanked = bl[s] || ((lzb != 0) && (s != 0) && allz);
      an = 8'((1 << nd) - 1);
      sg = 7'b1111111;
      dp = 1'b1;
      if (c >= 2 && !blanked) begin
         an[s] = 1'b0;
         sg    = ref_seg(dg[4*s +: 4]);
         dp    = ~dpv[s];
      end
      return {15'b0, (j == nd * 8), dp, sg, an};
   endfunction

   task automatic push_frame(input int nd, input int lzb, input logic [31:0] dg,
                             input logic [7:0] dpv, input logic [7:0] bl);
      for (int j = 1; j <= nd * 8; j++) sb_q.push_back(exp_entry(nd, lzb, dg, dpv, bl, j));
   endtask

   task automatic drive_load(input int sel, input logic v, input logic [31:0] dg,
                             input logic [7:0] dpv, input logic [7:0] bl);
      case (sel)
         0: begin load_a = v; digits_a = dg[15:0]; dp_a = dpv[3:0]; blank_a = bl[3:0]; end
         1: begin load_b = v; digits_b = dg[15:0]; dp_b = dpv[3:0]; blank_b = bl[3:0]; end
         default: begin load_c = v; digits_c = dg[3:0]; dp_c = dpv[0:0]; blank_c = bl[0:0]; end
      endcase
   endtask

   task automatic pulse_load(input int sel, input logic [31:0] dg, input logic [7:0] dpv,
                             input logic [7:0] bl);
      drive_load(sel, 1'b1, dg, dpv, bl);
      @(negedge clk);
      drive_load(sel, 1'b0, 32'h0, 8'h0, 8'h0);
   endtask

   // Advance to the next frame_done pulse; optionally require all anodes off meanwhile.
   task automatic wait_fd(input int sel, input bit chk_dark, input string tag);
      logic found;
      logic [31:0] o;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         o = obs(sel);
         if (o[16]) found = 1'b1;
         else if (chk_dark) check({tag, "_dark_an"}, {24'b0, o[7:0]}, (sel == 2) ? 32'h1 : 32'hF);
      end
      check({tag, "_fd_seen"}, {31'b0, found}, 32'h1);
   endtask

   // Compare n cycles against the scoreboard; optionally raise load after cycle inj.
   task automatic run_frame(input int sel, input int n, input int inj, input logic [31:0] dg,
                            input logic [7:0] dpv, input logic [7:0] bl, input string tag);
      logic [31:0] want;
      for (int j = 1; j <= n; j++) begin
         @(negedge clk);
         drive_load(sel, 1'b0, 32'h0, 8'h0, 8'h0);
         if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'h1);
         end else begin
            want = sb_q.pop_front();
            check(tag, obs(sel), want);
         end
         if (j == inj) drive_load(sel, 1'b1, dg, dpv, bl);
      end
      $display("frame %s sel=%0d cycles=%0d checks=%0d failures=%0d", tag, sel, n, checks, failures);
   endtask

   initial begin
      logic [31:0] o;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      drive_load(0, 1'b0, 32'h0, 8'h0, 8'h0);
      drive_load(1, 1'b0, 32'h0, 8'h0, 8'h0);
      drive_load(2, 1'b0, 32'h0, 8'h0, 8'h0);
      #2;
      check("a_reset_state", obs(0), {15'b0, 1'b0, 1'b1, 7'h7F, 8'h0F});
      check("b_reset_state", obs(1), {15'b0, 1'b0, 1'b1, 7'h7F, 8'h0F});
      check("c_reset_state", obs(2), {15'b0, 1'b0, 1'b1, 7'h7F, 8'h01});
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // Instance A: load, mid-frame reload, boundary load, forced blank
      repeat (3) @(negedge clk);
      pulse_load(0, 32'h1234, 8'h04, 8'h00);
      wait_fd(0, 1'b1, "a_first");
      push_frame(4, 0, 32'h1234, 8'h04, 8'h00);
      run_frame(0, 32, 0, 32'h0, 8'h0, 8'h0, "a_1234");
      push_frame(4, 0, 32'h1234, 8'h04, 8'h00);
      run_frame(0, 32, 10, 32'h5678, 8'h01, 8'h00, "a_1234_midload");
      push_frame(4, 0, 32'h5678, 8'h01, 8'h00);
      run_frame(0, 32, 31, 32'hAB0F, 8'h08, 8'h04, "a_5678_edgeload");
      push_frame(4, 0, 32'hAB0F, 8'h08, 8'h04);
      run_frame(0, 32, 0, 32'h0, 8'h0, 8'h0, "a_ab0f");

      // Asynchronous reset mid-slot with a load pending
      repeat (4) @(negedge clk);
      o = obs(0);
      check("a_pre_rst_an", {28'b0, o[3:0]}, 32'hE);
      drive_load(0, 1'b1, 32'h8888, 8'h0F, 8'h00);
      #2 rst_a = 1'b1;
      #1 check("a_async_rst", obs(0), {15'b0, 1'b0, 1'b1, 7'h7F, 8'h0F});
      @(negedge clk);
      drive_load(0, 1'b0, 32'h0, 8'h0, 8'h0);
      check("a_rst_held", obs(0), {15'b0, 1'b0, 1'b1, 7'h7F, 8'h0F});
      @(negedge clk);
      rst_a = 1'b0;
      wait_fd(0, 1'b1, "a_after_rst");
      push_frame(4, 0, 32'h0, 8'h00, 8'hFF);
      run_frame(0, 32, 0, 32'h0, 8'h0, 8'h0, "a_dark_after_rst");

      // Instance B: leading-zero blanking
      pulse_load(1, 32'h0070, 8'h00, 8'h00);
      wait_fd(1, 1'b1, "b_first");
      push_frame(4, 1, 32'h0070, 8'h00, 8'h00);
      run_frame(1, 32, 31, 32'h0000, 8'h01, 8'h00, "b_0070");
      push_frame(4, 1, 32'h0000, 8'h01, 8'h00);
      run_frame(1, 32, 31, 32'h1000, 8'h00, 8'h00, "b_0000");
      push_frame(4, 1, 32'h1000, 8'h00, 8'h00);
      run_frame(1, 32, 0, 32'h0, 8'h0, 8'h0, "b_1000");

      // Instance C: single digit, full decode sweep
      pulse_load(2, 32'h0, 8'h00, 8'h00);
      wait_fd(2, 1'b1, "c_first");
      for (int code = 0; code < 16; code++) begin
         push_frame(1, 0, 32'(code), 8'(code & 1), 8'h00);
         run_frame(2, 8, (code < 15) ? 7 : 0, 32'(code + 1), 8'((code + 1) & 1), 8'h00,
                   $sformatf("c_code_%0h", code));
      end

      check("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
